// File: rtl/spi_tx_fifo_pkg.sv
// Shared SPI controller package: default widths/depths and the TX FIFO status
// bundle handed to the status register block.
package SPI_package;

    localparam int SPI_DATA_WIDTH  = 32;
    localparam int SPI_TFIFO_DEPTH = 8;
    localparam int SPI_TFIFO_AW    = $clog2(SPI_TFIFO_DEPTH);

    typedef struct packed {
        logic                  full;
        logic                  empty;
        logic [SPI_TFIFO_AW:0] level;
        logic                  thr;
        logic                  ovf;
        logic                  udf;
    } tf2st;

endpackage

// File: rtl/spi_fifo_mem.sv
// Generic FIFO storage: one synchronous write port, one combinational read port.
// Contents are not reset; the owning FIFO tracks validity through its pointers.
module spi_fifo_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DEPTH-1:0][DW-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// SPI transmit FIFO with level/threshold status and sticky overflow/underflow.
// Define SPI_TFIFO_FWFT_EN for first-word fall-through read data; otherwise
// read data is registered and valid the cycle after an accepted read.
module spi_tx_fifo #(
    parameter int  SPI_DATA_WIDTH = SPI_package::SPI_DATA_WIDTH,
    parameter int  TFIFO_DEPTH    = SPI_package::SPI_TFIFO_DEPTH,
    localparam int TFIFO_AW       = $clog2(TFIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tfifo_wen,
    input  logic [SPI_DATA_WIDTH-1:0] wdata,
    input  logic                      tfifo_ren,
    output logic [SPI_DATA_WIDTH-1:0] tfifo_rdata,
    input  logic                      flush,
    input  logic                      err_clr,
    input  logic [TFIFO_AW:0]         thresh,
    output logic                      tfifo_full,
    output logic                      tfifo_empty,
    output logic [TFIFO_AW:0]         tfifo_level,
    output logic                      tfifo_thr,
    output logic                      tfifo_ovf,
    output logic                      tfifo_udf
);

    localparam logic [TFIFO_AW:0] FULL_LVL = (TFIFO_AW+1)'(TFIFO_DEPTH);

    logic [TFIFO_AW:0]         wptr, rptr;
    logic [SPI_DATA_WIDTH-1:0] mem_rd;
    logic                      rd_ok, wr_ok, ovf_set, udf_set;

    // Wrap bit makes full and empty distinguishable with a plain subtraction.
    assign tfifo_level = wptr - rptr;
    assign tfifo_empty = (tfifo_level == '0);
    assign tfifo_full  = (tfifo_level == FULL_LVL);
    assign tfifo_thr   = (tfifo_level <= thresh);

    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign rd_ok   = tfifo_ren && !tfifo_empty && !flush;
    assign wr_ok   = tfifo_wen && (!tfifo_full || rd_ok) && !flush;
    assign ovf_set = tfifo_wen && !flush && !wr_ok;
    assign udf_set = tfifo_ren && !flush && tfifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    // Set has priority so an error coinciding with err_clr is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tfifo_ovf <= 1'b0;
            tfifo_udf <= 1'b0;
        end else begin
            if (ovf_set)      tfifo_ovf <= 1'b1;
            else if (err_clr) tfifo_ovf <= 1'b0;
            if (udf_set)      tfifo_udf <= 1'b1;
            else if (err_clr) tfifo_udf <= 1'b0;
        end
    end

    spi_fifo_mem #(
        .DW    (SPI_DATA_WIDTH),
        .DEPTH (TFIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[TFIFO_AW-1:0]),
        .wdata (wdata),
        .raddr (rptr[TFIFO_AW-1:0]),
        .rdata (mem_rd)
    );

`ifdef SPI_TFIFO_FWFT_EN
    assign tfifo_rdata = tfifo_empty ? '0 : mem_rd;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        tfifo_rdata <= '0;
        else if (rd_ok) tfifo_rdata <= mem_rd;
    end
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed table-driven bench for spi_tx_fifo (DEPTH=8, 32-bit), both read modes.
module tb_spi_tx_fifo;
    import SPI_package::*;

    localparam int DW = 32;
    localparam logic [3:0] THR = 4'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          tfifo_wen, tfifo_ren, flush, err_clr;
    logic [DW-1:0] wdata, tfifo_rdata;
    logic [3:0]    thresh, tfifo_level;
    logic          tfifo_full, tfifo_empty, tfifo_thr, tfifo_ovf, tfifo_udf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_tx_fifo dut (
        .clk(clk), .rst(rst), .tfifo_wen(tfifo_wen), .wdata(wdata),
        .tfifo_ren(tfifo_ren), .tfifo_rdata(tfifo_rdata), .flush(flush),
        .err_clr(err_clr), .thresh(thresh), .tfifo_full(tfifo_full),
        .tfifo_empty(tfifo_empty), .tfifo_level(tfifo_level), .tfifo_thr(tfifo_thr),
        .tfifo_ovf(tfifo_ovf), .tfifo_udf(tfifo_udf)
    );

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic          f;
        logic          ec;
        logic          chk;
        logic [DW-1:0] ed;
        tf2st          es;
    } vec_t;

    vec_t vecs[$];

    function automatic tf2st st(input logic [3:0] lvl, input logic ovf, input logic udf);
        tf2st s;
        s.full  = (lvl == 4'd8);
        s.empty = (lvl == 4'd0);
        s.level = lvl;
        s.thr   = (lvl <= THR);
        s.ovf   = ovf;
        s.udf   = udf;
        return s;
    endfunction

    function automatic vec_t mk(input logic w, input logic [DW-1:0] d, input logic r,
                                input logic f, input logic ec, input logic chk,
                                input logic [DW-1:0] ed, input logic [3:0] lvl,
                                input logic ovf, input logic udf);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.f = f; v.ec = ec; v.chk = chk; v.ed = ed;
        v.es = st(lvl, ovf, udf);
        return v;
    endfunction

    function automatic tf2st act_st();
        tf2st s;
        s.full = tfifo_full; s.empty = tfifo_empty; s.level = tfifo_level;
        s.thr = tfifo_thr; s.ovf = tfifo_ovf; s.udf = tfifo_udf;
        return s;
    endfunction

    task automatic chk_st(input string name, input tf2st exp);
        tf2st a;
        a = act_st();
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s status: got full=%b empty=%b lvl=%0d thr=%b ovf=%b udf=%b, want full=%b empty=%b lvl=%0d thr=%b ovf=%b udf=%b",
                     name, a.full, a.empty, a.level, a.thr, a.ovf, a.udf,
                     exp.full, exp.empty, exp.level, exp.thr, exp.ovf, exp.udf);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] exp);
        checks++;
        if (tfifo_rdata !== exp) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, tfifo_rdata, exp);
        end
    endtask

    // FWFT shows the popped word before the edge; registered mode after it.
    task automatic step(input string name, input vec_t v);
        tfifo_wen = v.w; wdata = v.d; tfifo_ren = v.r; flush = v.f; err_clr = v.ec;
        #1;
`ifdef SPI_TFIFO_FWFT_EN
        if (v.chk) chk_d(name, v.ed);
`endif
        @(posedge clk);
        #1;
        tfifo_wen = 1'b0; tfifo_ren = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;
        chk_st(name, v.es);
`ifndef SPI_TFIFO_FWFT_EN
        if (v.chk) chk_d(name, v.ed);
`endif
    endtask

    initial begin
        // in-order 0x11/0x22/0x33
        vecs.push_back(mk(1, 32'h11, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h22, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 32'h33, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h11, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h22, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h33, 0, 0, 0));
        // fill to full, overflow, clear, simultaneous write+read at full
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 32'h100 + i, 0, 0, 0, 0, 0, 4'(i + 1), 0, 0));
        vecs.push_back(mk(1, 32'hDEAD, 0, 0, 0, 0, 0, 8, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8, 0, 0));
        vecs.push_back(mk(1, 32'hAA, 1, 0, 0, 1, 32'h100, 8, 0, 0));
        // drain: 0xDEAD never appears, 0xAA is last; thr crosses at level 2
        for (int i = 1; i < 8; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'h100 + i, 4'(8 - i), 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 32'hAA, 0, 0, 0));
        // underflow
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

        rst = 1'b1; tfifo_wen = 0; tfifo_ren = 0; flush = 0; err_clr = 0;
        wdata = '0; thresh = THR;
        #12;
        chk_st("reset", st(0, 0, 0));
        chk_d("reset", 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

`ifdef SPI_TFIFO_FWFT_EN
        chk_d("udf_rdata", 32'h0);
`else
        chk_d("udf_rdata_hold", 32'hAA);
`endif
        // error set beats err_clr, then plain clear
        step("udf_vs_clr", mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        step("udf_clr", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // empty with write+read: write lands, read rejected
        step("empty_wr", mk(1, 32'h77, 1, 0, 0, 0, 0, 1, 0, 1));
        step("empty_wr_rd", mk(0, 0, 1, 0, 0, 1, 32'h77, 0, 0, 1));
        step("clr2", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        // flush with a coincident write
        for (int i = 0; i < 5; i++)
            step($sformatf("fl_w%0d", i), mk(1, 32'h1 + i, 0, 0, 0, 0, 0, 4'(i + 1), 0, 0));
        step("flush", mk(1, 32'h99, 0, 1, 0, 0, 0, 0, 0, 0));
        step("post_fl_w", mk(1, 32'h55, 0, 0, 0, 0, 0, 1, 0, 0));
        step("post_fl_r", mk(0, 0, 1, 0, 0, 1, 32'h55, 0, 0, 0));

        // asynchronous reset mid-fill
        step("pre_rst_udf", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            step($sformatf("rst_w%0d", i), mk(1, 32'hC1 + i, 0, 0, 0, 0, 0, 4'(i + 1), 0, 1));
        #2;
        rst = 1'b1;
        #1;
        chk_st("async_rst", st(0, 0, 0));
        chk_d("async_rst", 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step("after_rst", mk(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_tx_fifo.md
# spi_tx_fifo

Transmit FIFO of the SPI controller, directly downstream of the APB slave. Each accepted APB write to the TX data address arrives as a one-cycle `tfifo_wen` strobe with `wdata`; the FIFO buffers these words and returns them in order to the SPI shift engine through a read-strobe interface. It reports full/empty state, fill level, a programmable low-water threshold and sticky overflow/underflow errors to the status/interrupt logic.

## Interface
- `SPI_DATA_WIDTH`, 32: word width (package constant, used as the parameter default)
- `TFIFO_DEPTH`, 8: number of entries; must be a power of two, ≥ 2
- `TFIFO_AW`, `$clog2(TFIFO_DEPTH)`: pointer width (derived; not overridden)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tfifo_wen`  in  1  write strobe from APB slave, one word per cycle
- `wdata`  in  SPI_DATA_WIDTH  write data, sampled when `tfifo_wen`=1
- `tfifo_ren`  in  1  read strobe from shift engine
- `tfifo_rdata`  out  SPI_DATA_WIDTH  read data
- `flush`  in  1  synchronous clear of contents and pointers
- `err_clr`  in  1  clears both sticky error flags
- `thresh`  in  TFIFO_AW+1  low-water threshold
- `tfifo_full`  out  1  level == TFIFO_DEPTH
- `tfifo_empty`  out  1  level == 0
- `tfifo_level`  out  TFIFO_AW+1  current entry count, 0..TFIFO_DEPTH
- `tfifo_thr`  out  1  level ≤ `thresh`
- `tfifo_ovf`  out  1  sticky: write attempted while full
- `tfifo_udf`  out  1  sticky: read attempted while empty

## Operation
- Storage: `TFIFO_DEPTH` × `SPI_DATA_WIDTH` register array; write and read pointers are `TFIFO_AW+1` bits wide, with the extra MSB as a wrap bit; level = wptr − rptr, computed modulo 2^(TFIFO_AW+1).
- Write accepted when `tfifo_wen` && (!full || read accepted in the same cycle); mem[wptr] ← wdata, wptr++.
- Read accepted when `tfifo_ren` && !empty; rptr++.
- Full with simultaneous write and read: both are accepted and level is unchanged.
- Empty with simultaneous write and read: the write is accepted and the read is rejected (underflow).
- Rejected write: data is discarded and `tfifo_ovf` is set. Rejected read: pointers are unchanged and `tfifo_udf` is set.
- Error flags: once set, each holds until `err_clr`. If `err_clr` and a new error occur in the same cycle, the set wins.
- `flush`: both pointers go to 0 on the next edge and any write or read in that cycle is ignored. Flush does not clear error flags.
- Pointers wrap naturally; there is no special case at index DEPTH−1 → 0.

## Timing
- Reset values: pointers 0; `tfifo_rdata`=0; `tfifo_empty`=1; `tfifo_full`=0; `tfifo_level`=0; `tfifo_ovf`=0; `tfifo_udf`=0; `tfifo_thr` = (0 ≤ `thresh`) = 1.
- Full, empty, level and thr are combinational from the registered pointers, so they update on the edge after the accepted access.
- A word written at edge N is readable (empty=0) from cycle N+1.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous); contents are lost.

## Configuration
- `SPI_TFIFO_FWFT_EN` defined (first-word fall-through):
  - `tfifo_rdata` = mem[rptr] combinationally while !empty, and 0 when empty.
  - A `tfifo_ren` pulse consumes the word already shown.
- `SPI_TFIFO_FWFT_EN` undefined (registered read):
  - On an accepted read, `tfifo_rdata` loads mem[rptr] at that edge, so data is valid the cycle after `tfifo_ren`.
  - Data holds until the next accepted read.
  - A rejected read and a flush leave `tfifo_rdata` unchanged.

## Structure
- Shared package `SPI_package`:
  - constants `SPI_DATA_WIDTH` and `SPI_TFIFO_DEPTH`
  - a `tf2st` struct bundling full/empty/level/thr/ovf/udf for the status register block
- Natural sub-module: `spi_fifo_mem`, a generic dual-pointer register array with one write and one read port, reusable by the RX FIFO. The flag and pointer logic stays in `spi_tx_fifo`.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles, then read 3 → data returned 0x11, 0x22, 0x33 in order (one cycle after each `ren` without FWFT, same cycle with FWFT); level goes 0→3→0; empty reasserts.
- Fill 8 words (DEPTH=8) → full=1, level=8. A 9th write of 0xDEAD → ovf=1 and the word is never read back. `err_clr` → ovf=0.
- Read while empty → udf=1, level stays 0, and without FWFT `tfifo_rdata` is unchanged.
- Full, then simultaneous wen(0xAA)+ren → head word popped, 0xAA stored, level stays 8, ovf stays 0.
- thresh=2: fill to 4, then drain → thr=0 at levels 4 and 3, thr=1 at levels 2, 1 and 0.
- Write 5 words, assert flush together with a wen → level=0, empty=1, the flushed-cycle word is discarded; a subsequent write of 0x55 is read back as the first word. Asserting `rst` mid-fill returns every output to its reset value.
